// File: rtl/mem_stage.sv
// Memory-access stage: byte-lane steering, load extension, valid/ready data-memory
// handshake with stall and timeout abort, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] sd,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  logic          wbValid_q, wbValid_d;
  logic          wbRegWrite_q, wbRegWrite_d;
  logic [4:0]    wbRd_q, wbRd_d;
  logic [31:0]   wbData_q, wbData_d;
  logic          wbMisalign_q, wbMisalign_d;
  logic          wbBusErr_q, wbBusErr_d;

  logic [1:0]    off;
  logic          memOp, misalign, alignedOp;
  logic          reqActive, timeoutHit, retireErr;
  logic [3:0]    laneBe;
  logic [31:0]   laneData, shifted, loadData;

  assign off       = alu_result[1:0];
  assign memOp     = ex_valid & (mem_read | mem_write);
  assign misalign  = (mem_size == 2'b11) | ((mem_size == 2'b01) & off[0]) |
                     ((mem_size == 2'b10) & (off != 2'b00));
  assign alignedOp = memOp & ~misalign;

  // Reset gates the request path so a pending access is dropped at once.
  assign reqActive  = rst & ((state_q == WAIT) | alignedOp);
  assign timeoutHit = (state_q == WAIT) & (count_q == CW'(TIMEOUT - 1));
  assign retireErr  = timeoutHit & ~dmem_ready;
  assign mem_stall  = reqActive & ~dmem_ready & ~timeoutHit;

  always_comb begin
    laneBe   = 4'b1111;
    laneData = sd;
    case (mem_size)
      2'b00: begin
        laneBe   = 4'b0001 << off;
        laneData = {4{sd[7:0]}};
      end
      2'b01: begin
        laneBe   = 4'b0011 << off;
        laneData = {2{sd[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_req   = reqActive;
  assign dmem_we    = reqActive & mem_write;
  assign dmem_be    = reqActive ? laneBe : 4'b0000;
  assign dmem_addr  = {alu_result[31:2], 2'b00};
  assign dmem_wdata = laneData;

  always_comb begin
    shifted  = dmem_rdata >> {off, 3'b000};
    loadData = dmem_rdata;
    case (mem_size)
      2'b00:   loadData = {{24{~mem_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   loadData = {{16{~mem_unsigned & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (reqActive & ~dmem_ready) begin
          state_d = WAIT;
          count_d = CW'(1);
        end
      end
      default: begin
        if (dmem_ready | timeoutHit) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    endcase
  end

  // A stalled or empty slot enters MEM/WB as a bubble.
  always_comb begin
    wbValid_d    = 1'b0;
    wbRegWrite_d = 1'b0;
    wbRd_d       = '0;
    wbData_d     = '0;
    wbMisalign_d = 1'b0;
    wbBusErr_d   = 1'b0;
    if (ex_valid & ~mem_stall) begin
      wbValid_d    = 1'b1;
      wbMisalign_d = memOp & misalign;
      wbBusErr_d   = retireErr;
      wbRegWrite_d = reg_write & ~(memOp & misalign) & ~retireErr;
      wbRd_d       = rd;
      wbData_d     = (alignedOp & mem_read & dmem_ready) ? loadData : alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wbValid_q    <= 1'b0;
      wbRegWrite_q <= 1'b0;
      wbRd_q       <= '0;
      wbData_q     <= '0;
      wbMisalign_q <= 1'b0;
      wbBusErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wbValid_q    <= wbValid_d;
      wbRegWrite_q <= wbRegWrite_d;
      wbRd_q       <= wbRd_d;
      wbData_q     <= wbData_d;
      wbMisalign_q <= wbMisalign_d;
      wbBusErr_q   <= wbBusErr_d;
    end
  end

  assign wb_valid     = wbValid_q;
  assign wb_reg_write = wbRegWrite_q;
  assign wb_rd        = wbRd_q;
  assign wb_data      = wbData_q;
  assign wb_misalign  = wbMisalign_q;
  assign wb_bus_err   = wbBusErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each transaction is predicted from the lane,
// extension and handshake rules, then checked cycle by cycle against the DUT.
module tb_mem_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write, mem_unsigned, reg_write;
  logic [31:0] alu_result, sd, dmem_rdata;
  logic [1:0]  mem_size;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we, dmem_ready, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_reg_write, wb_misalign, wb_bus_err;
  logic [4:0]  wb_rd;

  int checkCount = 0;
  int errCount   = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result), .sd(sd),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd(rd), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one EX/MEM slot; memory answers after waitc wait cycles (never if waitc is large).
  task automatic applyStimulus(input bit ev, input bit rdOp, input bit wrOp,
                               input logic [1:0] sz, input bit uns,
                               input logic [31:0] alu, input logic [31:0] sdv,
                               input logic [31:0] rdata, input logic [4:0] rdr,
                               input bit rw, input int waitc);
    int off, nBytes, stallN;
    bit memOpM, misM, reqM, busErrM;
    logic [31:0] expBe, expWd, expLoad, v;
    off    = int'(alu[1:0]);
    nBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    memOpM = ev && (rdOp || wrOp);
    misM   = memOpM && ((sz == 2'd3) || (off % nBytes) != 0);
    reqM   = memOpM && !misM;
    stallN = !reqM ? 0 : (waitc < TIMEOUT - 1) ? waitc : TIMEOUT - 1;
    busErrM = reqM && (waitc > TIMEOUT - 1);
    expBe = 32'd15;
    expWd = sdv;
    if (sz == 2'd0) begin
      expBe = 32'd1 << off;
      expWd = {24'd0, sdv[7:0]} * 32'h0101_0101;
    end else if (sz == 2'd1) begin
      expBe = 32'd3 << off;
      expWd = {16'd0, sdv[15:0]} * 32'h0001_0001;
    end
    v = rdata >> (8 * off);
    expLoad = rdata;
    if (sz == 2'd0) begin
      expLoad = v & 32'hFF;
      if (!uns && expLoad >= 32'd128) expLoad = expLoad | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      expLoad = v & 32'hFFFF;
      if (!uns && expLoad >= 32'd32768) expLoad = expLoad | 32'hFFFF_0000;
    end

    @(negedge clk);
    ex_valid = ev; mem_read = rdOp; mem_write = wrOp; mem_size = sz;
    mem_unsigned = uns; alu_result = alu; sd = sdv; dmem_rdata = rdata;
    rd = rdr; reg_write = rw;
    for (int k = 0; k <= stallN; k++) begin
      if (k > 0) @(negedge clk);
      dmem_ready = reqM && (k == waitc);
      #1;
      checkOutput("req", {31'd0, dmem_req}, {31'd0, reqM});
      checkOutput("stall", {31'd0, mem_stall}, {31'd0, k < stallN});
      if (reqM) begin
        checkOutput("addr", dmem_addr, alu & 32'hFFFF_FFFC);
        checkOutput("we", {31'd0, dmem_we}, {31'd0, wrOp});
        checkOutput("be", {28'd0, dmem_be}, expBe);
        if (wrOp) checkOutput("wdata", dmem_wdata, expWd);
      end
      @(posedge clk);
      #1;
      if (k < stallN) checkOutput("bubble", {31'd0, wb_valid}, 32'd0);
    end
    checkOutput("wbValid", {31'd0, wb_valid}, {31'd0, ev});
    checkOutput("wbRegWr", {31'd0, wb_reg_write}, {31'd0, ev && rw && !misM && !busErrM});
    checkOutput("wbMisalign", {31'd0, wb_misalign}, {31'd0, misM});
    checkOutput("wbBusErr", {31'd0, wb_bus_err}, {31'd0, busErrM});
    if (ev) checkOutput("wbRd", {27'd0, wb_rd}, {27'd0, rdr});
    if (ev && !misM && !busErrM && !(memOpM && wrOp))
      checkOutput("wbData", wb_data, (reqM && rdOp) ? expLoad : alu);
    dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
    mem_unsigned = 1'b0; reg_write = 1'b0; alu_result = '0; sd = '0; dmem_rdata = '0;
    rd = '0; dmem_ready = 1'b0;
    #3;
    checkOutput("rstValid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rstData", wb_data, 32'd0);
    checkOutput("rstReq", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd3, 1, 0);
    applyStimulus(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_0000, 5'd4, 1, 0);
    applyStimulus(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF_0000, 5'd4, 1, 0);
    applyStimulus(1, 0, 1, 2'd1, 0, 32'h102, 32'h1234_ABCD, 32'h0, 5'd0, 0, 3);
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h1111_1111, 5'd5, 1, 0);
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h200, 32'h0, 32'h2222_2222, 5'd6, 1, 1000);
    applyStimulus(1, 1, 0, 2'd1, 0, 32'h202, 32'h0, 32'h8001_0000, 5'd7, 1, TIMEOUT - 1);
    applyStimulus(1, 0, 0, 2'd0, 0, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd8, 1, 0);
    applyStimulus(0, 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 5'd9, 1, 0);

    // Reset asserted during the second WAIT cycle of a hung load.
    @(negedge clk);
    ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
    alu_result = 32'h400; reg_write = 1'b1; dmem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("preRstStall", {31'd0, mem_stall}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midRstReq", {31'd0, dmem_req}, 32'd0);
    checkOutput("midRstBe", {28'd0, dmem_be}, 32'd0);
    checkOutput("midRstStall", {31'd0, mem_stall}, 32'd0);
    checkOutput("midRstValid", {31'd0, wb_valid}, 32'd0);
    checkOutput("midRstRegWr", {31'd0, wb_reg_write}, 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    rst = 1'b1;
    applyStimulus(1, 1, 0, 2'd2, 0, 32'h404, 32'h0, 32'h5A5A_A5A5, 5'd10, 1, 1);

    for (int n = 0; n < 400; n++) begin
      int op, r, waitc;
      bit ev;
      op = $urandom_range(0, 2);
      ev = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 9);
      waitc = (r < 8) ? $urandom_range(0, 3) : $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
      applyStimulus(ev, op == 1, op == 2, 2'($urandom_range(0, 3)), 1'($urandom),
                    $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), waitc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RISC pipeline. It sits directly downstream of the execute stage. It consumes the EX/MEM register contents (ALU result used as address, store data, memory control) and drives a valid/ready data-memory port. It performs byte-lane steering and load extension, stalls the pipeline while memory is busy, aborts hung accesses on timeout, and registers the MEM/WB outputs.

## Interface
- TIMEOUT, 16: max cycles dmem_req may stay high without dmem_ready before the access is aborted (≥2).
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- alu_result  in  32  effective address, or result for non-memory ops.
- sd  in  32  store data (rs2).
- mem_read / mem_write  in  1 each  load / store; never both high.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_unsigned  in  1  zero-extend loads (LBU/LHU).
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  {alu_result[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  access completes this cycle; dmem_rdata valid.
- dmem_rdata  in  32  read word.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_valid, wb_reg_write  out  1 each  MEM/WB valid and write-enable.
- wb_rd  out  5, wb_data  out  32  MEM/WB destination and data.
- wb_misalign, wb_bus_err  out  1 each  exception flags in MEM/WB.

## Operation
- Definitions: mem_op = ex_valid & (mem_read | mem_write); off = alu_result[1:0].
- Misaligned when: half with off[0]=1; word with off≠0; or size 11.
- Misaligned op: no request and no stall. It retires with wb_misalign=1 and wb_reg_write=0.
- Store lanes:
  - byte: wdata = {4{sd[7:0]}}, be = 0001<<off.
  - half: wdata = {2{sd[15:0]}}, be = 0011<<off.
  - word: wdata = sd, be = 1111.
- For loads, be is computed the same way as for stores; dmem_we=0.
- Load data: rdata>>(8·off), then take the low byte or halfword. Sign-extend unless mem_unsigned. Word loads pass through.
- Non-memory op: wb_data = alu_result; retires next edge.
- FSM, state IDLE:
  - dmem_req = aligned mem_op (combinational from inputs).
  - If dmem_ready: retire this edge, stay IDLE.
  - Otherwise: go to WAIT, count=1, mem_stall=1.
- FSM, state WAIT:
  - dmem_req=1. Inputs are held stable by the upstream freeze.
  - If dmem_ready: retire, mem_stall=0, go to IDLE.
  - Else if count==TIMEOUT−1: abort. dmem_req stays high this cycle, mem_stall=0. Retire with wb_bus_err=1 and wb_reg_write=0, go to IDLE, count=0.
  - Else: count++, mem_stall=1.
- dmem_ready has priority over timeout in the same cycle.
- mem_stall = req_active & ~dmem_ready & ~timeout_hit (combinational).

## Timing
- Reset (async, rst=0):
  - state IDLE, count 0.
  - All wb_* outputs 0.
  - dmem_req, dmem_we and dmem_be are forced 0 immediately, including mid-WAIT. The aborted access is dropped.
- MEM/WB registers update on every rising edge.
  - While mem_stall=1, they load a bubble: wb_valid=0, wb_reg_write=0, flags 0.
- Latency:
  - non-memory or misaligned op: 1 cycle.
  - memory op with ready in the first request cycle: 1 cycle, no stall.
  - memory op with N wait cycles: N+1 cycles, mem_stall high N cycles.
  - timeout: TIMEOUT cycles.
- dmem_addr, dmem_we, dmem_be and dmem_wdata are stable while dmem_req=1 and dmem_ready=0.
- ex_valid=0 implies no request, no stall, and a bubble to MEM/WB.

## Test plan
- LW at 0x100, ready in the first cycle, rdata=0xDEADBEEF → req one cycle, no stall; next edge wb_data=0xDEADBEEF, wb_reg_write=1.
- LB at 0x103, rdata=0x80FF_0000 → wb_data=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH at 0x102, sd=0x1234ABCD, ready after 3 wait cycles → be=1100, wdata=0xABCDABCD; mem_stall high 3 cycles; wb_valid=0 during the stall, 1 at retire.
- LW at 0x101 → no dmem_req; next edge wb_misalign=1, wb_reg_write=0.
- Load with ready never asserted, TIMEOUT=16 → mem_stall high 15 cycles; retire with wb_bus_err=1; FSM returns to IDLE.
- rst=0 during WAIT (cycle 2) → dmem_req=0 and all wb_*=0 immediately. After release, a new LW completes normally.
